regfile_write_arbiter: RTL

//   Shares the single write port of the 32x32 register file between two writeback

---
 rtl/regfile_write_arbiter_if.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 73 +++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: request, regfile-write and hazard-query signals of regfile_write_arbiter.
// master = requesters/regfile side, slave = the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  Req0Valid;
  logic [ADDR_WIDTH-1:0] Req0Register;
  logic [DATA_WIDTH-1:0] Req0Data;
  logic                  Req0Ready;
  logic                  Req1Valid;
  logic [ADDR_WIDTH-1:0] Req1Register;
  logic [DATA_WIDTH-1:0] Req1Data;
  logic                  Req1Ready;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] HazardRegister1;
  logic [ADDR_WIDTH-1:0] HazardRegister2;
  logic                  Hazard;
  logic                  Idle;
  modport master (
    output Req0Valid, Req0Register, Req0Data, Req1Valid, Req1Register, Req1Data,
           HazardRegister1, HazardRegister2,
    input  Req0Ready, Req1Ready, WriteRegister, WriteData, RegWrite, Hazard, Idle
  );
  modport slave (
    input  Req0Valid, Req0Register, Req0Data, Req1Valid, Req1Register, Req1Data,
           HazardRegister1, HazardRegister2,
    output Req0Ready, Req1Ready, WriteRegister, WriteData, RegWrite, Hazard, Idle
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two 1-entry writeback buffers draining into the single regfile write port.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise Req0 has fixed priority.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                    Clk,
  input logic                    Reset,
  regfile_write_arbiter_if.slave bus
);
  logic                  full0_q, full0_d, full1_q, full1_d, wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] reg0_q, reg0_d, reg1_q, reg1_d, wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] dat0_q, dat0_d, dat1_q, dat1_d, wdat_q, wdat_d;
  logic                  grant0, grant1, keep0, keep1;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // last_q set means requester 1 was granted most recently
  assign grant0 = full0_q && (!full1_q || last_q);
  assign last_d = grant1 ? 1'b1 : grant0 ? 1'b0 : last_q;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) last_q <= 1'b1;
    else       last_q <= last_d;
`else
  assign grant0 = full0_q;
`endif
  assign grant1        = full1_q && !grant0;
  assign bus.Req0Ready = !full0_q || grant0;
  assign bus.Req1Ready = !full1_q || grant1;
  // writes to register 0 are acknowledged but dropped
  assign keep0 = bus.Req0Valid && bus.Req0Ready && |bus.Req0Register;
  assign keep1 = bus.Req1Valid && bus.Req1Ready && |bus.Req1Register;
  always_comb begin
    full0_d = keep0 || (full0_q && !grant0);
    full1_d = keep1 || (full1_q && !grant1);
    reg0_d  = keep0 ? bus.Req0Register : reg0_q;
    dat0_d  = keep0 ? bus.Req0Data     : dat0_q;
    reg1_d  = keep1 ? bus.Req1Register : reg1_q;
    dat1_d  = keep1 ? bus.Req1Data     : dat1_q;
    wen_d   = grant0 || grant1;
    wreg_d  = grant0 ? reg0_q : grant1 ? reg1_q : wreg_q;
    wdat_d  = grant0 ? dat0_q : grant1 ? dat1_q : wdat_q;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      reg0_q  <= '0;
      dat0_q  <= '0;
      reg1_q  <= '0;
      dat1_q  <= '0;
      wen_q   <= 1'b0;
      wreg_q  <= '0;
      wdat_q  <= '0;
    end else begin
      full0_q <= full0_d;
      full1_q <= full1_d;
      reg0_q  <= reg0_d;
      dat0_q  <= dat0_d;
      reg1_q  <= reg1_d;
      dat1_q  <= dat1_d;
      wen_q   <= wen_d;
      wreg_q  <= wreg_d;
      wdat_q  <= wdat_d;
    end
  function automatic logic pending(input logic [ADDR_WIDTH-1:0] a);
    return |a && ((full0_q && a == reg0_q) || (full1_q && a == reg1_q) || (wen_q && a == wreg_q));
  endfunction
  assign bus.Hazard        = pending(bus.HazardRegister1) || pending(bus.HazardRegister2);
  assign bus.Idle          = !full0_q && !full1_q && !wen_q;
  assign bus.RegWrite      = wen_q;
  assign bus.WriteRegister = wreg_q;
  assign bus.WriteData     = wdat_q;
endmodule
